// File: rtl/median_pkg.sv
// ---------------------------------------------------------------------------
// median_pkg
// Shared types and constants for the 3x3 median window controller.
//   pixel_t       8-bit pixel
//   ctrl_state_t  controller states IDLE / FILL / RUN / FLUSH
//   win_meta_t    per-window side-band bits carried beside the median
//   cnt_width()   counter width for a count range of n values
//   COL_W/ROW_W   counter widths for the default 640x480 geometry
// ---------------------------------------------------------------------------
package median_pkg;

    typedef logic [7:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } ctrl_state_t;

    // Side-band bits that ride along a window while calculate_median works on it
    typedef struct packed {
        logic valid;
        logic border;
        logic sof;
        logic eol;
    } win_meta_t;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_WIDTH  = 640;
    localparam int DEF_HEIGHT = 480;
    localparam int COL_W      = $clog2(DEF_WIDTH);
    localparam int ROW_W      = $clog2(DEF_HEIGHT);

endpackage

// File: rtl/line_buffer.sv
// ---------------------------------------------------------------------------
// line_buffer
// DEPTH-deep 8-bit delay line built as a circular RAM. Every enabled cycle
// the oldest entry is presented on dout and replaced by din, so dout is the
// pixel written DEPTH enables ago. RAM contents are not reset.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset (pointer only)
//   en    advance the delay line by one pixel
//   din   pixel entering the line
//   dout  pixel leaving the line (combinational read of the oldest entry)
// ---------------------------------------------------------------------------
module line_buffer
    import median_pkg::*;
#(
    parameter int DEPTH = 640
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    localparam int AW = cnt_width(DEPTH);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    pixel_t          mem [DEPTH];
    logic [AW-1:0]   ptr;

    assign dout = mem[ptr];

    // Storage: the slot being read this cycle is overwritten with the new pixel
    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= din;
        end
    end

    // Circular pointer, wraps after DEPTH advances
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + AW'(1);
        end
    end

endmodule

// File: rtl/median_window_ctrl.sv
// ---------------------------------------------------------------------------
// median_window_ctrl
// Raster-stream sequencer for the 3x3 calculate_median datapath. Accepts one
// pixel per handshake, builds a 3x3 window from two line buffers and a 3x3
// shift register, and aligns valid/sof/eol/border with the median latency.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   s_valid/s_ready      input pixel handshake
//   s_sof                first pixel of frame
//   s_data               input pixel
//   p0..p8               registered window, raster order, p4 = centre
//   median               result from calculate_median (MED_LAT cycles after p*)
//   out_valid/out_data   filtered pixel, no backpressure
//   out_sof/out_eol      first pixel of frame / last pixel of line
// Build option:
//   MEDIAN_BORDER_PASSTHROUGH_EN  border outputs carry the original centre
//                                 pixel; otherwise border outputs are 0.
// ---------------------------------------------------------------------------
module median_window_ctrl
    import median_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int HEIGHT  = DEF_HEIGHT,
    parameter int MED_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic       s_sof,
    input  logic [7:0] s_data,
    output logic [7:0] p0,
    output logic [7:0] p1,
    output logic [7:0] p2,
    output logic [7:0] p3,
    output logic [7:0] p4,
    output logic [7:0] p5,
    output logic [7:0] p6,
    output logic [7:0] p7,
    output logic [7:0] p8,
    input  logic [7:0] median,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_sof,
    output logic       out_eol
);

    localparam int CW = cnt_width(WIDTH);
    localparam int RW = cnt_width(HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    ctrl_state_t   state;
    logic [CW-1:0] in_col;
    logic [RW-1:0] in_row;
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    logic          acc;
    logic          restart;
    logic          adv;
    logic          emit;
    logic          last_in;
    logic          last_ctr;
    logic          fill_done;
    logic          border_now;
    pixel_t        shift_in;
    pixel_t        lb0_out;
    pixel_t        lb1_out;
    pixel_t        border_value;

    win_meta_t     win_meta;
    win_meta_t     dl [MED_LAT];

    assign acc        = s_valid & s_ready;
    assign restart    = acc & s_sof;
    assign adv        = (acc & ((state != IDLE) | s_sof)) | (state == FLUSH);
    assign emit       = ((state == RUN) & acc & ~s_sof) | (state == FLUSH);
    assign last_in    = (in_row == ROW_LAST) && (in_col == COL_LAST);
    assign last_ctr   = (row == ROW_LAST) && (col == COL_LAST);
    assign fill_done  = (in_row == RW'(1)) && (in_col == '0);
    assign border_now = (row == '0) || (row == ROW_LAST) ||
                        (col == '0) || (col == COL_LAST);
    assign shift_in   = (state == FLUSH) ? 8'd0 : s_data;

    // Two chained line buffers: lb0 yields the pixel one line above the
    // incoming one, lb1 the pixel two lines above.
    line_buffer #(.DEPTH(WIDTH)) u_lb0 (
        .clk  (clk),
        .rst  (rst),
        .en   (adv),
        .din  (shift_in),
        .dout (lb0_out)
    );

    line_buffer #(.DEPTH(WIDTH)) u_lb1 (
        .clk  (clk),
        .rst  (rst),
        .en   (adv),
        .din  (lb0_out),
        .dout (lb1_out)
    );

    // Controller FSM with input and centre counters. in_col/in_row hold the
    // raster index of the pixel being accepted; col/row hold the centre of
    // the next window to emit. s_ready is decided together with the next
    // state so it is low exactly while FLUSH runs. A SOF handshake in any
    // accepting state restarts the frame with this pixel as index 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            s_ready <= 1'b1;
            in_col  <= '0;
            in_row  <= '0;
            col     <= '0;
            row     <= '0;
        end else if (restart) begin
            state   <= FILL;
            s_ready <= 1'b1;
            in_col  <= CW'(1);
            in_row  <= '0;
            col     <= '0;
            row     <= '0;
        end else begin
            if (acc && (state == FILL || state == RUN)) begin
                in_col <= (in_col == COL_LAST) ? '0 : in_col + CW'(1);
                if (in_col == COL_LAST) begin
                    in_row <= (in_row == ROW_LAST) ? '0 : in_row + RW'(1);
                end
            end
            if (emit) begin
                col <= (col == COL_LAST) ? '0 : col + CW'(1);
                if (col == COL_LAST) begin
                    row <= (row == ROW_LAST) ? '0 : row + RW'(1);
                end
            end
            case (state)
                IDLE: begin
                    s_ready <= 1'b1;
                end
                FILL: begin
                    if (acc && fill_done) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (acc && last_in) begin
                        state   <= FLUSH;
                        s_ready <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (last_ctr) begin
                        state   <= IDLE;
                        s_ready <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    s_ready <= 1'b1;
                end
            endcase
        end
    end

    // 3x3 window shift register. Each advance moves every row one column to
    // the left and loads the new right column from (lb1, lb0, incoming), so
    // the centre lands WIDTH+1 pixels behind the newest input. The side-band
    // bits for the window are registered in the same cycle as the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {p0, p1, p2, p3, p4, p5, p6, p7, p8} <= '0;
            win_meta <= '0;
        end else begin
            if (adv) begin
                p0 <= p1;
                p1 <= p2;
                p2 <= lb1_out;
                p3 <= p4;
                p4 <= p5;
                p5 <= lb0_out;
                p6 <= p7;
                p7 <= p8;
                p8 <= shift_in;
            end
            win_meta.valid  <= emit;
            win_meta.border <= emit & border_now;
            win_meta.sof    <= emit & (row == '0) & (col == '0);
            win_meta.eol    <= emit & (col == COL_LAST);
        end
    end

    // Latency-matching delay line: the window side-band arrives at the
    // output in the same cycle as calculate_median produces its result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MED_LAT; i++) begin
                dl[i] <= '0;
            end
        end else begin
            dl[0] <= win_meta;
            for (int i = 1; i < MED_LAT; i++) begin
                dl[i] <= dl[i-1];
            end
        end
    end

`ifdef MEDIAN_BORDER_PASSTHROUGH_EN
    pixel_t centre_dl [MED_LAT];

    // Original centre pixel travels beside the median so border positions
    // can pass it through unfiltered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MED_LAT; i++) begin
                centre_dl[i] <= '0;
            end
        end else begin
            centre_dl[0] <= p4;
            for (int i = 1; i < MED_LAT; i++) begin
                centre_dl[i] <= centre_dl[i-1];
            end
        end
    end

    assign border_value = centre_dl[MED_LAT-1];
`else
    assign border_value = 8'd0;
`endif

    // Output mux: median is only trusted for interior positions, and data is
    // held at zero whenever no pixel is being presented.
    assign out_valid = dl[MED_LAT-1].valid;
    assign out_sof   = dl[MED_LAT-1].sof;
    assign out_eol   = dl[MED_LAT-1].eol;
    assign out_data  = !dl[MED_LAT-1].valid ? 8'd0 :
                       (dl[MED_LAT-1].border ? border_value : median);

endmodule

// File: tb/tb_median_window_ctrl.sv
// ---------------------------------------------------------------------------
// tb_median_window_ctrl
// Directed bench for median_window_ctrl at WIDTH=4, HEIGHT=4, MED_LAT=2 with
// a behavioural two-stage calculate_median beside it. Honours
// MEDIAN_BORDER_PASSTHROUGH_EN for the expected border values.
// ---------------------------------------------------------------------------
module tb_median_window_ctrl;

    localparam int W   = 4;
    localparam int H   = 4;
    localparam int LAT = 2;
    localparam int N   = W * H;

    logic       clk;
    logic       rst;
    logic       s_valid;
    logic       s_ready;
    logic       s_sof;
    logic [7:0] s_data;
    logic [7:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
    logic [7:0] median;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_sof;
    logic       out_eol;

    logic [7:0] med_s1;
    logic [7:0] img [N];
    logic [9:0] capq [$];

    int vectors;
    int miscompares;
    int low_cnt;

    median_window_ctrl #(
        .WIDTH   (W),
        .HEIGHT  (H),
        .MED_LAT (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_sof     (s_sof),
        .s_data    (s_data),
        .p0        (p0),
        .p1        (p1),
        .p2        (p2),
        .p3        (p3),
        .p4        (p4),
        .p5        (p5),
        .p6        (p6),
        .p7        (p7),
        .p8        (p8),
        .median    (median),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sof   (out_sof),
        .out_eol   (out_eol)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Median of nine pixels packed as {a0, a1, ..., a8}
    function automatic logic [7:0] med9(input logic [71:0] v);
        logic [7:0] a [9];
        logic [7:0] t;
        for (int i = 0; i < 9; i++) a[i] = v[i*8 +: 8];
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8 - i; j++) begin
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
            end
        end
        return a[4];
    endfunction

    // Behavioural calculate_median: two register stages
    always @(posedge clk) begin
        med_s1 <= med9({p0, p1, p2, p3, p4, p5, p6, p7, p8});
        median <= med_s1;
    end

    // Output capture: {sof, eol, data} per filtered pixel
    always @(negedge clk) begin
        if (out_valid) capq.push_back({out_sof, out_eol, out_data});
    end

    // Expected filtered pixel at (r, c) computed from the image neighbourhood
    function automatic logic [7:0] exp_pix(input int r, input int c);
        if (r == 0 || r == H-1 || c == 0 || c == W-1) begin
`ifdef MEDIAN_BORDER_PASSTHROUGH_EN
            return img[r*W + c];
`else
            return 8'd0;
`endif
        end
        return med9({img[(r-1)*W+c-1], img[(r-1)*W+c], img[(r-1)*W+c+1],
                     img[r*W+c-1],     img[r*W+c],     img[r*W+c+1],
                     img[(r+1)*W+c-1], img[(r+1)*W+c], img[(r+1)*W+c+1]});
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Stream img[] as one frame; gaps=1 idles s_valid on about half the
    // cycles. Returns the number of cycles s_ready stayed low afterwards.
    task automatic applyStimulus(input bit gaps, output int low);
        int i;
        int guard;
        i = 0;
        guard = 0;
        while (i < N && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (gaps && $urandom_range(0, 1) == 0) begin
                s_valid = 1'b0;
                s_sof   = 1'b0;
            end else begin
                s_valid = 1'b1;
                s_data  = img[i];
                s_sof   = (i == 0);
                if (s_ready) i++;
            end
        end
        if (i < N) checkOutput("accept_timeout", i, N);
        @(negedge clk);
        s_valid = 1'b0;
        s_sof   = 1'b0;
        low = 0;
        while (!s_ready && low < 50) begin
            low++;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic checkFrame(input string tag);
        logic [7:0] e;
        checkOutput({tag, "_count"}, capq.size(), N);
        for (int i = 0; i < N; i++) begin
            if (i < capq.size()) begin
                e = exp_pix(i / W, i % W);
                checkOutput($sformatf("%s_data%0d", tag, i), capq[i][7:0], e);
                checkOutput($sformatf("%s_sof%0d", tag, i), capq[i][9], (i == 0));
                checkOutput($sformatf("%s_eol%0d", tag, i), capq[i][8], ((i % W) == W-1));
            end
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_s_ready"},   s_ready,   1);
        checkOutput({tag, "_out_valid"}, out_valid, 0);
        checkOutput({tag, "_out_data"},  out_data,  0);
        checkOutput({tag, "_out_sof"},   out_sof,   0);
        checkOutput({tag, "_out_eol"},   out_eol,   0);
        checkOutput({tag, "_win_lo"}, {p0, p1, p2, p3}, 0);
        checkOutput({tag, "_win_hi"}, {p4, p5, p6, p7, p8}, 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_data  = 8'd0;
        repeat (3) @(negedge clk);
        checkIdleOutputs("reset");
        rst = 1'b0;

        // Constant frame of 50
        for (int i = 0; i < N; i++) img[i] = 8'd50;
        capq.delete();
        applyStimulus(1'b0, low_cnt);
        checkFrame("const");
        if (capq.size() > 5) begin
            checkOutput("const_interior_hand", capq[5][7:0], 50);
`ifdef MEDIAN_BORDER_PASSTHROUGH_EN
            checkOutput("const_border_hand", capq[0][7:0], 50);
`else
            checkOutput("const_border_hand", capq[0][7:0], 0);
`endif
        end

        // Impulse at (1,1) is removed
        for (int i = 0; i < N; i++) img[i] = 8'd10;
        img[5] = 8'd255;
        capq.delete();
        applyStimulus(1'b0, low_cnt);
        checkFrame("impulse");
        if (capq.size() > 5) checkOutput("impulse_hand", capq[5][7:0], 10);

        // Window at (1,1) loaded with 10..90
        for (int i = 0; i < N; i++) img[i] = 8'd0;
        img[0] = 8'd10; img[1] = 8'd20; img[2]  = 8'd30;
        img[4] = 8'd40; img[5] = 8'd50; img[6]  = 8'd60;
        img[8] = 8'd70; img[9] = 8'd80; img[10] = 8'd90;
        capq.delete();
        applyStimulus(1'b0, low_cnt);
        checkFrame("ramp");
        if (capq.size() > 5) checkOutput("ramp_hand", capq[5][7:0], 50);

        // Varied frame back-to-back, then the same frame with gaps
        for (int i = 0; i < N; i++) img[i] = 8'((i * 37 + 11) % 256);
        capq.delete();
        applyStimulus(1'b0, low_cnt);
        checkOutput("flush_ready_low_cycles", low_cnt, W + 1);
        checkFrame("b2b");

        capq.delete();
        applyStimulus(1'b1, low_cnt);
        checkOutput("gaps_flush_ready_low_cycles", low_cnt, W + 1);
        checkFrame("gaps");

        // Reset mid-RUN, then a fresh frame
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = img[k];
            s_sof   = (k == 0);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_sof   = 1'b0;
        rst = 1'b1;
        #1;
        checkIdleOutputs("midrun_reset");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) img[i] = 8'((i * 91 + 3) % 256);
        capq.delete();
        applyStimulus(1'b0, low_cnt);
        checkFrame("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
